uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 19200, SHALL be the clock frequency in Hz.
REQ-002 Parameter BAUDRATE, default 9600, SHALL be the line bit rate in bits/s.
REQ-003 Parameter DATA_WIDTH, default 8, SHALL be the number of data bits per frame.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous assertion, active-low.
REQ-006 line  input  1  SHALL be the serial RX line, asynchronous to clk, idle high.
REQ-007 data  output  DATA_WIDTH  SHALL hold the last correctly received byte.
REQ-008 valid  output  1  SHALL pulse high for one cycle when data is updated.
REQ-009 frame_err  output  1  SHALL pulse high for one cycle when a frame has a bad stop bit.
REQ-010 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-011 Frame format SHALL be 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1), no parity.
REQ-012 CPB = CLK_FREQ/BAUDRATE (integer division), HALF = CPB/2; CPB SHALL be >= 2. Counter width = clog2(CPB)+1.
REQ-013 line SHALL pass through a 2-flop synchronizer reset to 1; the FSM SHALL use only the synchronized value.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-015 IDLE: a synchronized 0 SHALL move to START and clear the bit counter and cycle counter.
REQ-016 START: HALF cycles after entry, sample; 0 -> DATA with counter cleared; 1 -> IDLE (false start, no output pulse).
REQ-017 DATA: every CPB cycles, sample one bit into a shift register (MSB-in, right shift); after DATA_WIDTH samples -> STOP.
REQ-018 STOP: CPB cycles after the last data sample, sample; 1 -> data <= shift register, valid = 1 for that cycle, -> IDLE.
REQ-019 STOP sample of 0 -> frame_err = 1 for one cycle, data unchanged, valid stays 0, -> WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL remain until the synchronized line is 1, then -> IDLE; a held-low line (break) SHALL NOT produce frames.
REQ-021 valid and frame_err SHALL never be high in the same cycle; both SHALL be registered outputs.
REQ-022 A start bit immediately following a good stop bit (back-to-back frames) SHALL be received without loss.
REQ-023 Latency: valid SHALL rise 2 + HALF + (DATA_WIDTH+1)*CPB cycles (+-1) after the start-bit falling edge on line.
REQ-024 No flow control: a new valid SHALL overwrite data regardless of consumer state.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, data = 0, valid = 0, frame_err = 0, busy = 0, synchronizer flops = 1, counters = 0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame without any output pulse; reception SHALL restart on the next start bit after rst_n high.

Verification (DATA_WIDTH=8, CLK_FREQ=76800, BAUDRATE=9600 -> CPB=8 unless stated)
REQ-027 Send 0x55 with a valid stop bit -> exactly one valid pulse, data = 0x55, frame_err never high, busy low afterwards.
REQ-028 Send 0xA3 then 0x0F back-to-back -> two valid pulses 80 cycles apart (+-1), data 0xA3 then 0x0F.
REQ-029 Drive line low for 2 cycles then high -> busy pulses, returns to IDLE, no valid, no frame_err.
REQ-030 After 0x55, send 0x3C with stop bit 0 and hold line low 40 cycles -> one frame_err pulse, data stays 0x55, no valid; after line high, send 0x81 -> valid, data = 0x81.
REQ-031 Assert rst_n low after 4 data bits of 0xFF, release, send 0xC6 -> all outputs 0 during reset, no pulse for the aborted frame, then valid with data = 0xC6.
REQ-032 Loopback uart_tx.line -> uart_rx.line at CLK_FREQ=19200, BAUDRATE=9600 fed by rom_fetcher/rom -> received bytes match ROM contents in address order, frame_err never high.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchronizer, start-bit validation at mid-bit,
// LSB-first data capture, stop-bit check with registered valid/frame_err pulses.
//
// state     | meaning
// IDLE      | line high, waiting for a falling edge
// START     | timing to mid start bit; high there is a false start
// DATA      | one sample per bit period into the shift register
// STOP      | one bit period after last data sample, check stop bit
// WAIT_IDLE | bad stop bit seen, hold off until the line returns high
module uart_rx #(
  parameter int CLK_FREQ   = 19200,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  line,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CPB   = CLK_FREQ / BAUDRATE;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB) + 1;
  localparam int BIT_W = $clog2(DATA_WIDTH) + 1;

  localparam logic [CNT_W-1:0] CPB_TC  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_TC  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t                state;
  logic [1:0]            sync_q;
  logic                  line_s;
  logic [CNT_W-1:0]      cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift;

  assign line_s = sync_q[1];
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b11;
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], line};
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!line_s) begin
            state   <= START;
            cnt     <= '0;
            bit_cnt <= '0;
          end
        end
        START: begin
          if (cnt == HALF_TC) begin
            cnt   <= '0;
            state <= line_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CPB_TC) begin
            cnt   <= '0;
            // right shift with the new bit entering at the MSB: LSB-first line order
            shift <= DATA_WIDTH'({line_s, shift} >> 1);
            if (bit_cnt == BIT_TC) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == CPB_TC) begin
            cnt <= '0;
            if (line_s) begin
              data  <= shift;
              valid <= 1'b1;
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_IDLE: begin
          if (line_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: CPB=8 instance for functional scenarios, CPB=2 instance
// for a back-to-back ROM stream; received bytes checked against a queue.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       line_a, line_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, ferr_a, busy_a;
  logic       valid_b, ferr_b, busy_b;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  int fall_cyc  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] exp2_q[$];
  logic [7:0] got2_q[$];
  int         ferr2_cnt = 0;

  uart_rx #(.CLK_FREQ(76800), .BAUDRATE(9600), .DATA_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .line(line_a),
    .data(data_a), .valid(valid_a), .frame_err(ferr_a), .busy(busy_a)
  );

  uart_rx #(.CLK_FREQ(19200), .BAUDRATE(9600), .DATA_WIDTH(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .line(line_b),
    .data(data_b), .valid(valid_b), .frame_err(ferr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a) begin
      got_q.push_back(data_a);
      got_cyc_q.push_back(cyc);
    end
    if (ferr_a) ferr_cnt++;
    if (valid_a && ferr_a) both_cnt++;
    if (valid_b) got2_q.push_back(data_b);
    if (ferr_b) ferr2_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v, input int n);
    if (sel == 0) line_a = v;
    else          line_b = v;
    tick(n);
  endtask

  task automatic send(input int sel, input logic [7:0] b, input logic stop, input int cpb);
    fall_cyc = cyc;
    drive(sel, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(sel, b[i], cpb);
    drive(sel, stop, cpb);
  endtask

  task automatic test_reset;
    #3;
    total_cnt++;
    if ({data_a, valid_a, ferr_a, busy_a} !== 11'd0) begin
      $display("FAIL reset_outputs: got data=%h valid=%b ferr=%b busy=%b want all 0",
               data_a, valid_a, ferr_a, busy_a);
    end else pass_cnt++;
    tick(3);
    rst_n = 1'b1;
    tick(8);
    total_cnt++;
    if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
      $display("FAIL idle_after_reset: got busy=%b valid=%b want 0 0", busy_a, valid_a);
    end else pass_cnt++;
  endtask

  task automatic test_single;
    logic [7:0] e, g;
    exp_q.push_back(8'h55);
    send(0, 8'h55, 1'b1, 8);
    tick(12);
    total_cnt++;
    if (got_q.size() !== 1) begin
      $display("FAIL single_count: got %0d valid pulses want 1", got_q.size());
    end else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      void'(got_cyc_q.pop_front());
      total_cnt++;
      if (g !== e) $display("FAIL single_data: got %h want %h", g, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (ferr_cnt !== 0 || busy_a !== 1'b0) begin
      $display("FAIL single_status: got ferr_cnt=%0d busy=%b want 0 0", ferr_cnt, busy_a);
    end else pass_cnt++;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] e, g;
    int         c0, c1, f0, lat;
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    send(0, 8'hA3, 1'b1, 8);
    f0 = fall_cyc;
    send(0, 8'h0F, 1'b1, 8);
    tick(12);
    total_cnt++;
    if (got_q.size() !== 2) begin
      $display("FAIL b2b_count: got %0d valid pulses want 2", got_q.size());
    end else begin
      pass_cnt++;
      c0  = got_cyc_q[0];
      c1  = got_cyc_q[1];
      lat = c0 - f0;
      total_cnt++;
      if (c1 - c0 < 79 || c1 - c0 > 81) $display("FAIL b2b_spacing: got %0d cycles want 80+-1", c1 - c0);
      else pass_cnt++;
      total_cnt++;
      if (lat < 77 || lat > 79) $display("FAIL latency: got %0d cycles want 78+-1", lat);
      else pass_cnt++;
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total_cnt++;
      if (g !== e) $display("FAIL b2b_data: got %h want %h", g, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (both_cnt !== 0 || ferr_cnt !== 0) begin
      $display("FAIL b2b_err: got ferr_cnt=%0d overlap=%0d want 0 0", ferr_cnt, both_cnt);
    end else pass_cnt++;
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic test_false_start;
    int busy_cycles = 0;
    drive(0, 1'b0, 2);
    line_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (busy_a === 1'b1) busy_cycles++;
      tick(1);
    end
    total_cnt++;
    if (busy_cycles == 0) $display("FAIL false_start_busy: got 0 busy cycles want >0");
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() !== 0 || ferr_cnt !== 0 || busy_a !== 1'b0) begin
      $display("FAIL false_start_quiet: got valids=%0d ferr=%0d busy=%b want 0 0 0",
               got_q.size(), ferr_cnt, busy_a);
    end else pass_cnt++;
  endtask

  task automatic test_frame_err;
    logic [7:0] e, g;
    exp_q.push_back(8'h55);
    send(0, 8'h55, 1'b1, 8);
    tick(4);
    send(0, 8'h3C, 1'b0, 8);
    drive(0, 1'b0, 20);
    total_cnt++;
    if (busy_a !== 1'b1) $display("FAIL break_busy: got busy=%b want 1", busy_a);
    else pass_cnt++;
    drive(0, 1'b0, 20);
    total_cnt++;
    if (ferr_cnt !== 1) $display("FAIL frame_err_count: got %0d want 1", ferr_cnt);
    else pass_cnt++;
    total_cnt++;
    if (data_a !== 8'h55 || got_q.size() !== 1) begin
      $display("FAIL frame_err_data: got data=%h valids=%0d want 55 1", data_a, got_q.size());
    end else pass_cnt++;
    drive(0, 1'b1, 10);
    total_cnt++;
    if (busy_a !== 1'b0) $display("FAIL wait_idle_exit: got busy=%b want 0", busy_a);
    else pass_cnt++;
    exp_q.push_back(8'h81);
    send(0, 8'h81, 1'b1, 8);
    tick(12);
    total_cnt++;
    if (got_q.size() !== 2) $display("FAIL after_err_count: got %0d valids want 2", got_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total_cnt++;
      if (g !== e) $display("FAIL after_err_data: got %h want %h", g, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (both_cnt !== 0) $display("FAIL overlap: got %0d cycles with valid&frame_err want 0", both_cnt);
    else pass_cnt++;
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
    ferr_cnt = 0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] e, g;
    drive(0, 1'b0, 8);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, 8);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({data_a, valid_a, ferr_a, busy_a} !== 11'd0) begin
      $display("FAIL reset_mid_outputs: got data=%h valid=%b ferr=%b busy=%b want all 0",
               data_a, valid_a, ferr_a, busy_a);
    end else pass_cnt++;
    tick(1);
    line_a = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(16);
    total_cnt++;
    if (got_q.size() !== 0 || ferr_cnt !== 0) begin
      $display("FAIL aborted_frame: got valids=%0d ferr=%0d want 0 0", got_q.size(), ferr_cnt);
    end else pass_cnt++;
    exp_q.push_back(8'hC6);
    send(0, 8'hC6, 1'b1, 8);
    tick(12);
    total_cnt++;
    if (got_q.size() !== 1) $display("FAIL reset_recover_count: got %0d valids want 1", got_q.size());
    else pass_cnt++;
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      total_cnt++;
      if (g !== e) $display("FAIL reset_recover_data: got %h want %h", g, e);
      else pass_cnt++;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_loopback;
    logic [7:0] rom [8];
    logic [7:0] e, g;
    rom = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h7E, 8'hC3};
    got2_q.delete();
    ferr2_cnt = 0;
    for (int a = 0; a < 8; a++) begin
      exp2_q.push_back(rom[a]);
      send(1, rom[a], 1'b1, 2);
    end
    tick(8);
    total_cnt++;
    if (got2_q.size() !== 8) $display("FAIL loop_count: got %0d bytes want 8", got2_q.size());
    else pass_cnt++;
    while (exp2_q.size() > 0 && got2_q.size() > 0) begin
      e = exp2_q.pop_front();
      g = got2_q.pop_front();
      total_cnt++;
      if (g !== e) $display("FAIL loop_data: got %h want %h", g, e);
      else pass_cnt++;
    end
    total_cnt++;
    if (ferr2_cnt !== 0) $display("FAIL loop_ferr: got %0d frame errors want 0", ferr2_cnt);
    else pass_cnt++;
  endtask

  initial begin
    rst_n  = 1'b0;
    line_a = 1'b1;
    line_b = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_reset_mid();
    test_loopback();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
